// File: rtl/rbus_egress_pktbuf.sv
// Two-lane store-and-forward egress buffer for one rbus output channel.
// Only complete packets are forwarded, and each one is sent without gaps.
// Lane 1 (priority) is served before lane 0 whenever both can go.
module rbus_egress_pktbuf #(
  parameter int DEPTH    = 32,
  parameter int MAX_PKT  = 9,
  parameter int LANE_BIT = 71
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stb,
  input  logic        i_sof,
  input  logic [71:0] i_data,
  output logic [1:0]  i_rdy,
  output logic [1:0]  i_rdyE,
  output logic        o_stb,
  output logic        o_sof,
  output logic [71:0] o_data,
  input  logic [1:0]  o_rdy,
  input  logic [1:0]  o_rdyE,
  output logic        ff_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_PKT + 1);

  typedef enum logic {IDLE, SEND} state_t;

  // Both lane FIFOs share one memory, addressed as {lane, pointer}.
  // Bit 72 of each entry holds the sof flag.
  logic [72:0]          mem [2*DEPTH];
  logic [2*DEPTH-1:0]   sof_bits;

  logic [1:0][AW-1:0]   wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [1:0][AW:0]     used_reg, used_next, pkt_reg, pkt_next;
  logic [1:0]           push, pop_l, inc, dec, full, avail, rdy_next, rdye_next;
  logic [1:0]           rdy_reg, rdye_reg;

  logic                 open_reg, open_next, open_lane_reg, open_lane_next;
  logic [CW-1:0]        open_cnt_reg, open_cnt_next;
  logic                 drop_reg, drop_next, err_reg, err_set;
  logic                 wr_en, wr_lane, end_pkt;

  state_t               state_reg, state_next;
  logic                 sel_reg, sel_next, pop, pop_lane;
  logic                 head_sof;

  // o_rdyE carries no flow-control meaning here.
  logic unused_ok;
  assign unused_ok = ^o_rdyE;

  // An open packet closes on an idle cycle or on a back-to-back sof.
  assign end_pkt = open_reg && (!i_stb || i_sof);

  // Input framing: accept, drop or flag each arriving word.
  always_comb begin
    wr_en          = 1'b0;
    wr_lane        = open_lane_reg;
    open_next      = open_reg && !end_pkt;
    open_lane_next = open_lane_reg;
    open_cnt_next  = open_cnt_reg;
    drop_next      = drop_reg;
    err_set        = 1'b0;
    if (i_stb && i_sof) begin
      wr_lane        = i_data[LANE_BIT];
      open_lane_next = i_data[LANE_BIT];
      if (full[wr_lane]) begin
        err_set   = 1'b1;
        open_next = 1'b0;
      end else begin
        wr_en         = 1'b1;
        open_next     = 1'b1;
        open_cnt_next = CW'(1);
        drop_next     = 1'b0;
      end
    end else if (i_stb) begin
      if (!open_reg || drop_reg) begin
        err_set = 1'b1;
      end else if (open_cnt_reg == CW'(MAX_PKT) || full[open_lane_reg]) begin
        // Truncate: the rest of this packet is discarded, the head is kept.
        err_set   = 1'b1;
        drop_next = 1'b1;
      end else begin
        wr_en         = 1'b1;
        open_cnt_next = open_cnt_reg + CW'(1);
      end
    end
  end

  // Per-lane bookkeeping: pointers, occupancy, committed packet count, flags.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign push[gi]        = wr_en && (wr_lane == 1'(gi));
    assign pop_l[gi]       = pop && (pop_lane == 1'(gi));
    assign inc[gi]         = end_pkt && (open_lane_reg == 1'(gi));
    assign full[gi]        = (used_reg[gi] == (AW+1)'(DEPTH));
    assign avail[gi]       = (pkt_reg[gi] != '0) || inc[gi];
    assign wr_ptr_next[gi] = wr_ptr_reg[gi] + AW'(push[gi]);
    assign rd_ptr_next[gi] = rd_ptr_reg[gi] + AW'(pop_l[gi]);
    assign used_next[gi]   = used_reg[gi] + (AW+1)'(push[gi]) - (AW+1)'(pop_l[gi]);
    assign pkt_next[gi]    = pkt_reg[gi] + (AW+1)'(inc[gi]) - (AW+1)'(dec[gi]);
    assign rdy_next[gi]    = (used_next[gi] <= (AW+1)'(DEPTH - MAX_PKT));
    assign rdye_next[gi]   = (used_next[gi] == '0) &&
                             !(open_next && (open_lane_next == 1'(gi)));
  end

  assign head_sof = sof_bits[{sel_reg, rd_ptr_reg[sel_reg]}];

  // Output sequencer: pick a lane in IDLE, stream one packet in SEND.
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    pop        = 1'b0;
    pop_lane   = sel_reg;
    dec        = 2'b00;
    case (state_reg)
      IDLE: begin
        if (avail[1] && o_rdy[1]) begin
          sel_next = 1'b1; pop = 1'b1; pop_lane = 1'b1; state_next = SEND;
        end else if (avail[0] && o_rdy[0]) begin
          sel_next = 1'b0; pop = 1'b1; pop_lane = 1'b0; state_next = SEND;
        end
      end
      SEND: begin
        if (used_reg[sel_reg] == '0 || head_sof) begin
          dec[sel_reg] = 1'b1;
          state_next   = IDLE;
        end else begin
          pop = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Word storage, written the cycle each accepted word arrives.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_lane, wr_ptr_reg[wr_lane]}]      <= {i_sof, i_data};
      sof_bits[{wr_lane, wr_ptr_reg[wr_lane]}] <= i_sof;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      used_reg      <= '0;
      pkt_reg       <= '0;
      rdy_reg       <= 2'b00;
      rdye_reg      <= 2'b00;
      open_reg      <= 1'b0;
      open_lane_reg <= 1'b0;
      open_cnt_reg  <= '0;
      drop_reg      <= 1'b0;
      err_reg       <= 1'b0;
      state_reg     <= IDLE;
      sel_reg       <= 1'b0;
      o_stb         <= 1'b0;
      o_sof         <= 1'b0;
      o_data        <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      used_reg      <= used_next;
      pkt_reg       <= pkt_next;
      rdy_reg       <= rdy_next;
      rdye_reg      <= rdye_next;
      open_reg      <= open_next;
      open_lane_reg <= open_lane_next;
      open_cnt_reg  <= open_cnt_next;
      drop_reg      <= drop_next;
      err_reg       <= err_reg | err_set;
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      o_stb         <= pop;
      if (pop) begin
        {o_sof, o_data} <= mem[{pop_lane, rd_ptr_reg[pop_lane]}];
      end
    end
  end

  assign i_rdy  = rdy_reg;
  assign i_rdyE = rdye_reg;
  assign ff_err = err_reg;
endmodule

// File: doc/rbus_egress_pktbuf.md
Name: rbus_egress_pktbuf

Overview:
- Store-and-forward packet buffer on one rbus output channel. It sits directly downstream of one o_[k] port of the N-to-M channel mux.
- Holds two independent lanes (lane 0 = normal, lane 1 = priority); the lane is chosen by a header bit of the sof word.
- Generates per-lane rdy/rdyE back-pressure toward the mux. Forwards only complete packets, with no internal gaps, to the next rbus consumer.

Parameters:
- DEPTH, 32, words per lane FIFO; power of two, at least 2*MAX_PKT.
- MAX_PKT, 9, maximum packet length in words, sof word included.
- LANE_BIT, 71, index of the i_data bit in the sof word that selects the lane.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- i_stb  input  1  input word valid
- i_sof  input  1  first word of packet (qualified by i_stb)
- i_data  input  72  input word
- i_rdy  output  2  bit l=1: lane l has at least MAX_PKT free words
- i_rdyE  output  2  bit l=1: lane l completely empty (no stored words, no open packet)
- o_stb  output  1  output word valid
- o_sof  output  1  first word of output packet
- o_data  output  72  output word
- o_rdy  input  2  downstream lane l can accept one whole packet
- o_rdyE  input  2  downstream lane l empty; informational only, not used for flow control
- ff_err  output  1  sticky protocol/overflow error

Behaviour:
- Reset (async): FIFOs empty, packet counters 0, no open packet, o_stb=0, o_sof=0, o_data=0, i_rdy=2'b00, i_rdyE=2'b00, ff_err=0. First clk edge after release: i_rdy=2'b11, i_rdyE=2'b11.
- All outputs are registered.
- Input framing: a packet is the sof word plus the following contiguous i_stb words.
  - A packet ends at the first cycle with i_stb=0, or with i_stb=1 and i_sof=1 (back-to-back packet).
  - Lane is latched from i_data[LANE_BIT] of the sof word.
  - Words are written to the lane FIFO the cycle they arrive, with the sof flag stored alongside as bit 72.
- Commit: when a packet ends, that lane's complete-packet counter increments at the same edge. A word with i_sof=1 in the same cycle opens the next packet.
- i_rdy[l] = (DEPTH − used_l) >= MAX_PKT, where used_l counts committed and open words; registered, so it updates 1 cycle after a write or read.
- Upstream must start a lane-l packet only when i_rdy[l]=1.
- i_rdyE[l] = 1 when used_l=0 and no lane-l packet is open; registered.
- Output FSM:
  - IDLE: if lane 1 has a committed packet and o_rdy[1]=1, select lane 1. Otherwise, if lane 0 has a committed packet and o_rdy[0]=1, select lane 0. Otherwise stay.
  - SEND: pop one word per cycle with o_stb=1; o_sof=1 on the first word only.
  - The packet ends when the next FIFO head has sof=1 or the lane FIFO is empty. At that point decrement the packet counter and return to IDLE; o_stb=0 for at least 1 cycle between packets.
  - o_rdy is sampled only in IDLE. A packet once started is never interrupted.
- Latency: last word at t, end detected at t+1, earliest o_stb with o_sof=1 at t+2.
- Simultaneous push and pop on one lane are allowed; the used_l count nets correctly.
- Errors (ff_err set, sticky until rst; the offending word is dropped):
  - write to a full lane;
  - i_stb=1 with i_sof=0 while no packet is open;
  - the (MAX_PKT+1)-th word of a packet. The rest of that packet is dropped and the partial packet is committed truncated.
- Reset asserted mid-packet: everything is cleared immediately; partial packets are discarded.

Test Plan:
- Single packet: lane 0, 4 words (D0..D3) at cycles 10–13, o_rdy=2'b11 -> o_stb at 15–18, o_sof only at 15, data D0..D3 in order; i_rdyE[0] goes 0 at 11 and 1 once drained.
- Priority: lane-0 and lane-1 packets both committed while o_rdy=0; then o_rdy=2'b11 -> lane-1 packet output first, at least 1 idle cycle, then lane 0.
- Back-pressure: o_rdy[1]=0, o_rdy[0]=1 with both lanes holding packets -> only lane 0 is sent; raising o_rdy[1] releases lane 1 at the next IDLE.
- Fill: DEPTH=32, MAX_PKT=9, three 8-word lane-0 packets with o_rdy=0 -> i_rdy[0]=0 after used=24; an extra 9-word packet overflows after 8 words -> ff_err=1; lane 1 is unaffected and i_rdy[1] stays 1.
- Framing errors: stb without sof -> ff_err=1, word dropped; a 10-word packet -> 9 words forwarded, ff_err=1.
- Reset mid-packet: rst pulse after word 2 of 5 -> outputs 0 immediately; a fresh packet after release is forwarded intact and ff_err=0.
